pc_fetch_unit: RTL
==================

// Module: pc_fetch_unit
// PURPOSE
//  Instruction-fetch stage directly upstream of the instruction decoder. Holds the PC,
//  fetches instr from instruction memory via req/ack, presents it to the decoder, and
//  computes next PC from decoder's pc_control (seq/J/JR/branch). Two-phase (FETCH, EXEC)
//  per instruction, matching the single-issue datapath; traps misalignment and fetch timeouts.
// PARAMETERS
//  RESET_PC   32'h0000_0000  PC loaded on reset; must be word-aligned
//  WAIT_MAX   16             max cycles imem_req may stay unacknowledged before fetch_err
//  CNT_W      5              width of wait counter; must hold WAIT_MAX
// PORTS
//  clk            in   1   single clock, rising edge
//  rst            in   1   asynchronous, active-high reset
//  pc_control     in   3   from decoder: 000 seq, 001 J/JAL, 010 JR/JALR, 011 taken branch, others = seq
//  jr_target      in   32  rs register value, used for 010
//  stall          in   1   hold EXEC (instr, pc unchanged) while high
//  imem_req       out  1   fetch request; imem_addr stable while high
//  imem_addr      out  32  word-aligned fetch address (= pc)
//  imem_ack       in   1   imem_rdata valid this cycle; ignored unless imem_req high
//  imem_rdata     in   32  fetched word
//  instr          out  32  current instruction to decoder (registered)
//  instr_valid    out  1   instr/pc describe an instruction in EXEC
//  pc             out  32  address of instr
//  pc_plus4       out  32  pc + 4 (link value for JAL/JALR), combinational from pc
//  retired        out  32  count of EXEC->FETCH advances, wraps 2^32-1 -> 0
//  fetch_err      out  1   sticky: WAIT_MAX reached without ack
//  misalign_err   out  1   sticky: computed next PC has [1:0] != 0
// BEHAVIOUR
//  Reset (async, immediate, any state): pc=RESET_PC, instr=32'h0 (NOP), instr_valid=0,
//   imem_req=0, retired=0, wait counter=0, both errors=0, state=BOOT. Reset mid-fetch abandons req.
//  States: BOOT -> FETCH -> EXEC -> FETCH ...; FETCH/EXEC -> HALT on error; HALT exits only by rst.
//  BOOT: one cycle, no outputs asserted; -> FETCH.
//  FETCH: imem_req=1, imem_addr=pc, instr_valid=0. Zero-wait ack (same cycle as first req) allowed.
//   On ack: instr<=imem_rdata, instr_valid<=1, counter<=0, -> EXEC (fetch latency min 1 cycle).
//   No ack: counter++; counter==WAIT_MAX-1 with no ack -> fetch_err<=1, imem_req drops, -> HALT.
//   Ack in the same cycle as the timeout wins (no error).
//  EXEC: imem_req=0; pc_control sampled at clock edge (decoder output settles within cycle).
//   stall=1: hold everything, retired unchanged. stall=0: pc<=next_pc, retired++, instr_valid<=0, -> FETCH.
//  next_pc (32-bit, wrap mod 2^32):
//   000/1xx: pc+4;  001: {pc_plus4[31:28], instr[25:0], 2'b00};  010: jr_target;
//   011: pc_plus4 + {{14{instr[15]}}, instr[15:0], 2'b00}  (sign-extended word offset).
//  Misalign: next_pc[1:0]!=0 at EXEC advance -> misalign_err<=1, pc unchanged, retired unchanged, -> HALT.
//  HALT: imem_req=0, instr_valid=0, pc frozen at faulting instr; errors remain set.
//  pc_control changes during FETCH/BOOT/HALT are ignored. pc 32'hFFFF_FFFC + 4 wraps to 0 without error.
// TESTING
//  1 Reset, RESET_PC=0, ack 0-wait, imem returns NOPs -> pc 0,4,8 on EXEC; retired=3 after 3 advances.
//  2 Ack delayed 3 cycles -> imem_req high 4 cycles, addr constant; instr_valid rises cycle after ack.
//  3 pc=0x0040_0010, instr=0x0810_0000 (J), pc_control=001 -> next pc=0x0040_0000.
//  4 pc=0x100, instr imm=16'hFFFE, pc_control=011 -> pc=0xFC; control=000 -> 0x104.
//  5 pc_control=010, jr_target=0x203 -> misalign_err=1, HALT, pc stays; jr_target=0x200 -> pc=0x200.
//  6 No ack for WAIT_MAX=16 cycles -> fetch_err=1, imem_req=0; rst mid-FETCH -> all outputs reset values.

Source files
------------

// File: rtl/pc_fetch_if.sv
// Instruction-memory fetch channel: the fetch unit raises req/addr, memory answers with ack/rdata.
interface pc_fetch_if;
  logic        req;
  logic [31:0] addr;
  logic        ack;
  logic [31:0] rdata;

  modport master (output req, output addr, input ack, input rdata);
  modport slave  (input req, input addr, output ack, output rdata);
endinterface

// File: rtl/pc_fetch_unit.sv
// Fetch stage: holds the PC, fetches each word over the imem channel, then selects the next PC
// from the decoder's pc_control after the EXEC phase. Misaligned targets and fetch timeouts halt.
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned WAIT_MAX = 16,
  parameter int unsigned CNT_W    = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  i_pc_control,
  input  logic [31:0] i_jr_target,
  input  logic        i_stall,
  pc_fetch_if.master  imem,
  output logic [31:0] o_instr,
  output logic        o_instr_valid,
  output logic [31:0] o_pc,
  output logic [31:0] o_pc_plus4,
  output logic [31:0] o_retired,
  output logic        o_fetch_err,
  output logic        o_misalign_err
);

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_FETCH = 2'd1,
    ST_EXEC  = 2'd2,
    ST_HALT  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_MAX - 1);

  state_t           r_state, w_state_nxt;
  logic [31:0]      r_pc, w_pc_nxt;
  logic [31:0]      r_instr, w_instr_nxt;
  logic             r_instr_valid, w_instr_valid_nxt;
  logic             r_req, w_req_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [31:0]      r_retired, w_retired_nxt;
  logic             r_fetch_err, w_fetch_err_nxt;
  logic             r_misalign_err, w_misalign_err_nxt;
  logic [31:0]      w_pc_plus4;
  logic [31:0]      w_next_pc;

  assign w_pc_plus4 = r_pc + 32'd4;

  // Next-PC selection; all arithmetic wraps modulo 2^32.
  always_comb begin
    w_next_pc = w_pc_plus4;
    case (i_pc_control)
      3'b001:  w_next_pc = {w_pc_plus4[31:28], r_instr[25:0], 2'b00};
      3'b010:  w_next_pc = i_jr_target;
      3'b011:  w_next_pc = w_pc_plus4 + {{14{r_instr[15]}}, r_instr[15:0], 2'b00};
      default: w_next_pc = w_pc_plus4;
    endcase
  end

  // FSM next state and register next values; imem_req is registered so it follows the state.
  always_comb begin
    w_state_nxt        = r_state;
    w_pc_nxt           = r_pc;
    w_instr_nxt        = r_instr;
    w_instr_valid_nxt  = r_instr_valid;
    w_req_nxt          = 1'b0;
    w_cnt_nxt          = r_cnt;
    w_retired_nxt      = r_retired;
    w_fetch_err_nxt    = r_fetch_err;
    w_misalign_err_nxt = r_misalign_err;
    case (r_state)
      ST_BOOT: begin
        w_state_nxt = ST_FETCH;
        w_req_nxt   = 1'b1;
        w_cnt_nxt   = {CNT_W{1'b0}};
      end
      ST_FETCH: begin
        if (r_req && imem.ack) begin
          w_instr_nxt       = imem.rdata;
          w_instr_valid_nxt = 1'b1;
          w_cnt_nxt         = {CNT_W{1'b0}};
          w_state_nxt       = ST_EXEC;
        end else if (r_cnt == CNT_LAST) begin
          w_fetch_err_nxt = 1'b1;
          w_state_nxt     = ST_HALT;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
          w_req_nxt = 1'b1;
        end
      end
      ST_EXEC: begin
        if (i_stall) begin
          w_state_nxt = ST_EXEC;
        end else if (w_next_pc[1:0] != 2'b00) begin
          w_misalign_err_nxt = 1'b1;
          w_instr_valid_nxt  = 1'b0;
          w_state_nxt        = ST_HALT;
        end else begin
          w_pc_nxt          = w_next_pc;
          w_retired_nxt     = r_retired + 32'd1;
          w_instr_valid_nxt = 1'b0;
          w_req_nxt         = 1'b1;
          w_cnt_nxt         = {CNT_W{1'b0}};
          w_state_nxt       = ST_FETCH;
        end
      end
      ST_HALT: begin
        w_instr_valid_nxt = 1'b0;
        w_state_nxt       = ST_HALT;
      end
      default: begin
        w_state_nxt = ST_BOOT;
      end
    endcase
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= ST_BOOT;
      r_pc           <= RESET_PC;
      r_instr        <= 32'h0000_0000;
      r_instr_valid  <= 1'b0;
      r_req          <= 1'b0;
      r_cnt          <= {CNT_W{1'b0}};
      r_retired      <= 32'd0;
      r_fetch_err    <= 1'b0;
      r_misalign_err <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_pc           <= w_pc_nxt;
      r_instr        <= w_instr_nxt;
      r_instr_valid  <= w_instr_valid_nxt;
      r_req          <= w_req_nxt;
      r_cnt          <= w_cnt_nxt;
      r_retired      <= w_retired_nxt;
      r_fetch_err    <= w_fetch_err_nxt;
      r_misalign_err <= w_misalign_err_nxt;
    end
  end

  assign imem.req       = r_req;
  assign imem.addr      = r_pc;
  assign o_instr        = r_instr;
  assign o_instr_valid  = r_instr_valid;
  assign o_pc           = r_pc;
  assign o_pc_plus4     = w_pc_plus4;
  assign o_retired      = r_retired;
  assign o_fetch_err    = r_fetch_err;
  assign o_misalign_err = r_misalign_err;

endmodule
